// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC accumulator and its adder.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    localparam int MAC_PROD_W    = 8;
    localparam int MAC_ACC_W     = 10;
    localparam int MAC_BLOCK_LEN = 8;
    localparam int MAC_CNT_W     = $clog2(MAC_BLOCK_LEN);

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / block-sum-out handshake bundle for the MAC accumulator.
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int PROD_W = MAC_PROD_W,
    parameter int ACC_W  = MAC_ACC_W,
    parameter int CNT_W  = MAC_CNT_W
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum;
    logic              sat;
    logic [CNT_W-1:0]  count;

    // Side that feeds products and consumes block sums.
    modport master (
        output clear, in_valid, product, out_ready,
        input  in_ready, out_valid, sum, sat, count
    );

    // The accumulator itself.
    modport slave (
        input  clear, in_valid, product, out_ready,
        output in_ready, out_valid, sum, sat, count
    );
endinterface

// File: rtl/sat_adder.sv
// Unsigned saturating adder: acc + zero-extended operand, clamped to all-ones.
module sat_adder #(
    parameter int ACC_W  = 10,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  y,
    output logic              ovf
);
    logic [ACC_W:0] wide;

    // One extra bit catches the carry; a carry means the true sum is unrepresentable.
    always_comb begin
        wide = {1'b0, a} + (ACC_W + 1)'(b);
        ovf  = wide[ACC_W];
        y    = ovf ? '1 : wide[ACC_W-1:0];
    end
endmodule

// File: rtl/mac_accumulator.sv
// Sums fixed-length blocks of products into a saturating accumulator and
// presents each block sum with a sticky saturation flag.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W    = MAC_PROD_W,
    parameter int ACC_W     = MAC_ACC_W,
    parameter int BLOCK_LEN = MAC_BLOCK_LEN,
    parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    mac_accumulator_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    mac_state_t       state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic             sat_reg, sat_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [ACC_W-1:0] add_y;
    logic             add_ovf;

    sat_adder #(
        .ACC_W  (ACC_W),
        .PROD_W (PROD_W)
    ) u_sat_adder (
        .a   (acc_reg),
        .b   (bus.product),
        .y   (add_y),
        .ovf (add_ovf)
    );

    // State, accumulator, flag and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ACCUM;
            acc_reg   <= '0;
            sat_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            sat_reg   <= sat_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic: clear beats both handshakes; HOLD ignores products.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        count_next = count_reg;
        if (bus.clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            sat_next   = 1'b0;
            count_next = '0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_next = add_y;
                        sat_next = sat_reg | add_ovf;
                        if (count_reg == LAST_IDX) begin
                            count_next = '0;
                            state_next = HOLD;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        sat_next   = 1'b0;
                    end
                end
                default: state_next = ACCUM;
            endcase
        end
    end

    // Handshake outputs depend on state only, so no input-to-output path exists.
    always_comb begin
        bus.in_ready  = (state_reg == ACCUM);
        bus.out_valid = (state_reg == HOLD);
        bus.sum       = acc_reg;
        bus.sat       = sat_reg;
        bus.count     = count_reg;
    end
endmodule
